// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the program-counter / instruction-fetch slice:
// fetch FSM state encoding, default sequential PC step and datapath word width.
package pc_fetch_pkg;

   // Datapath word width, shared by the offset shifter and branch target adder
   localparam int WORD_W = 32;

   // Default sequential fetch increment in bytes
   localparam int unsigned FETCH_PC_STEP = 4;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target adder: BranchBasePC + ShiftedOffset, modulo 2^WORD_W.
// The offset arrives already sign-extended to full width, so a plain
// two's-complement add covers both forward and backward branches.
module branch_target_adder
   import pc_fetch_pkg::*;
(
   input  logic [WORD_W-1:0] i_base,
   input  logic [WORD_W-1:0] i_offset,
   output logic [WORD_W-1:0] o_target
);

   logic signed [WORD_W-1:0] w_base_s;
   logic signed [WORD_W-1:0] w_offset_s;
   logic signed [WORD_W-1:0] w_sum_s;

   assign w_base_s   = i_base;
   assign w_offset_s = i_offset;
   // Carry out of the top bit is dropped on purpose: targets wrap silently
   assign w_sum_s    = w_base_s + w_offset_s;
   assign o_target   = w_sum_s;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage. Keeps the PC, issues req/ack fetches to
// instruction memory and holds one fetched instruction for decode behind a
// valid/ready handshake. Branch redirects have priority over everything;
// a redirect that lands while a request is outstanding is remembered as a
// squash so the in-flight address stays stable until its ack returns.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds sticky MisalignErr and
// forces redirect targets to word alignment).
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned       PC_STEP  = FETCH_PC_STEP
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              BranchTaken,
   input  logic [WORD_W-1:0] BranchBasePC,
   input  logic [WORD_W-1:0] ShiftedOffset,
   output logic              ImemReq,
   output logic [WORD_W-1:0] ImemAddr,
   input  logic              ImemAck,
   input  logic [WORD_W-1:0] ImemRdata,
   output logic              InstValid,
   output logic [WORD_W-1:0] InstOut,
   output logic [WORD_W-1:0] InstPCPlus4,
   input  logic              InstReady
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic              MisalignErr
`endif
);

   localparam logic [1:0]        S_IDLE  = ST_IDLE;
   localparam logic [1:0]        S_FETCH = ST_FETCH;
   localparam logic [1:0]        S_WAIT  = ST_WAIT;
   localparam logic [WORD_W-1:0] STEP    = WORD_W'(PC_STEP);

   logic [1:0]        r_state;
   logic [WORD_W-1:0] r_pc;
   logic              r_squash;
   logic              r_req;
   logic [WORD_W-1:0] r_addr;
   logic              r_valid;
   logic [WORD_W-1:0] r_inst;
   logic [WORD_W-1:0] r_pcp4;

   logic [WORD_W-1:0] w_target;
   logic [WORD_W-1:0] w_target_ld;
   logic [WORD_W-1:0] w_pc_inc;
   logic              w_buf_free;

   branch_target_adder u_target_adder (
      .i_base   (BranchBasePC),
      .i_offset (ShiftedOffset),
      .o_target (w_target)
   );

`ifdef PC_ALIGN_CHECK_EN
   logic r_misalign;

   assign w_target_ld = {w_target[WORD_W-1:2], 2'b00};
   assign MisalignErr = r_misalign;

   // Sticky flag: any redirect to a non-word-aligned target, cleared only by reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_misalign <= 1'b0;
      end else if (BranchTaken && (w_target[1:0] != 2'b00)) begin
         r_misalign <= 1'b1;
      end
   end
`else
   assign w_target_ld = w_target;
`endif

   // Sequential PC wraps naturally at the top of the address space
   assign w_pc_inc   = r_pc + STEP;
   // Buffer can take a new word if empty or being drained this cycle
   assign w_buf_free = ~r_valid | InstReady;

   assign ImemReq     = r_req;
   assign ImemAddr    = r_addr;
   assign InstValid   = r_valid;
   assign InstOut     = r_inst;
   assign InstPCPlus4 = r_pcp4;

   // Fetch FSM: PC update, memory request, squash tracking and instruction buffer
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_squash <= 1'b0;
         r_req    <= 1'b0;
         r_addr   <= RESET_PC;
         r_valid  <= 1'b0;
         r_inst   <= '0;
         r_pcp4   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
               if (BranchTaken) begin
                  r_pc    <= w_target_ld;
                  r_addr  <= w_target_ld;
                  r_valid <= 1'b0;
               end else begin
                  r_addr  <= r_pc;
               end
            end

            S_FETCH: begin
               if (BranchTaken) begin
                  // Flush the wrong-path word; a consumer handshake this cycle still completes
                  r_valid <= 1'b0;
                  r_pc    <= w_target_ld;
                  if (ImemAck) begin
                     // Response belongs to the old path: drop it and go straight to the target
                     r_addr   <= w_target_ld;
                     r_squash <= 1'b0;
                  end else begin
                     // Keep the outstanding address stable; its ack will be discarded
                     r_squash <= 1'b1;
                  end
               end else if (ImemAck) begin
                  if (r_squash) begin
                     r_squash <= 1'b0;
                     r_addr   <= r_pc;
                     if (InstReady) begin
                        r_valid <= 1'b0;
                     end
                  end else if (w_buf_free) begin
                     r_inst  <= ImemRdata;
                     r_pcp4  <= w_pc_inc;
                     r_valid <= 1'b1;
                     r_pc    <= w_pc_inc;
                     if (InstReady) begin
                        r_addr  <= w_pc_inc;
                     end else begin
                        // Buffer now full with no consumer: stop requesting
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                     end
                  end
                  // Otherwise the word has nowhere to go; PC and address are
                  // left untouched so the same word is simply fetched again.
               end else if (InstReady) begin
                  r_valid <= 1'b0;
               end
            end

            S_WAIT: begin
               if (BranchTaken) begin
                  r_pc    <= w_target_ld;
                  r_addr  <= w_target_ld;
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end else if (InstReady) begin
                  r_valid <= 1'b0;
                  r_addr  <= r_pc;
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit. Builds with or without
// PC_ALIGN_CHECK_EN; the alignment scenario adapts to the build.
module tb_pc_fetch_unit;

   logic        Clk;
   logic        Reset;
   logic        BranchTaken;
   logic [31:0] BranchBasePC;
   logic [31:0] ShiftedOffset;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck;
   logic [31:0] ImemRdata;
   logic        InstValid;
   logic [31:0] InstOut;
   logic [31:0] InstPCPlus4;
   logic        InstReady;
`ifdef PC_ALIGN_CHECK_EN
   logic        MisalignErr;
`endif

   int n_checks;
   int n_fail;

   pc_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (4)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .BranchTaken   (BranchTaken),
      .BranchBasePC  (BranchBasePC),
      .ShiftedOffset (ShiftedOffset),
      .ImemReq       (ImemReq),
      .ImemAddr      (ImemAddr),
      .ImemAck       (ImemAck),
      .ImemRdata     (ImemRdata),
      .InstValid     (InstValid),
      .InstOut       (InstOut),
      .InstPCPlus4   (InstPCPlus4),
      .InstReady     (InstReady)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .MisalignErr   (MisalignErr)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1ns after the edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_branch(input logic tk, input logic [31:0] base, input logic [31:0] off);
      BranchTaken   = tk;
      BranchBasePC  = base;
      ShiftedOffset = off;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset = 1'b1;
      set_branch(1'b0, 32'h0, 32'h0);
      ImemAck   = 1'b0;
      ImemRdata = 32'h0;
      InstReady = 1'b0;

      // Reset state
      #3;
      check_eq("rst_req",   {31'b0, ImemReq},   32'h0);
      check_eq("rst_addr",  ImemAddr,           32'h0);
      check_eq("rst_valid", {31'b0, InstValid}, 32'h0);
      check_eq("rst_inst",  InstOut,            32'h0);
      check_eq("rst_pcp4",  InstPCPlus4,        32'h0);
      tick();
      tick();
      Reset = 1'b0;

      // Sequential fetch, ack every cycle, decode always ready
      InstReady = 1'b1;
      tick();
      check_eq("seq_req0",  {31'b0, ImemReq}, 32'h1);
      check_eq("seq_addr0", ImemAddr,         32'h0);
      ImemAck = 1'b1; ImemRdata = 32'hA000_0000;
      tick();
      check_eq("seq_addr1", ImemAddr,           32'h4);
      check_eq("seq_val1",  {31'b0, InstValid}, 32'h1);
      check_eq("seq_inst1", InstOut,            32'hA000_0000);
      check_eq("seq_pcp41", InstPCPlus4,        32'h4);
      ImemRdata = 32'hA000_0001;
      tick();
      check_eq("seq_addr2", ImemAddr,    32'h8);
      check_eq("seq_inst2", InstOut,     32'hA000_0001);
      check_eq("seq_pcp42", InstPCPlus4, 32'h8);
      ImemRdata = 32'hA000_0002;
      tick();
      check_eq("seq_addr3", ImemAddr,    32'hC);
      check_eq("seq_inst3", InstOut,     32'hA000_0002);
      check_eq("seq_pcp43", InstPCPlus4, 32'hC);
      ImemAck = 1'b0;
      tick();
      check_eq("seq_drain", {31'b0, InstValid}, 32'h0);
      check_eq("seq_hold",  ImemAddr,           32'hC);

      // Backpressure: buffer fills with decode stalled, fetch pauses, resumes at 8
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
      ImemAck = 1'b1; ImemRdata = 32'hB000_0000; InstReady = 1'b1;
      tick();
      check_eq("bp_inst0", InstOut, 32'hB000_0000);
      ImemAck = 1'b0;
      tick();
      InstReady = 1'b0; ImemAck = 1'b1; ImemRdata = 32'hB000_0001;
      tick();
      check_eq("bp_req_drop", {31'b0, ImemReq},   32'h0);
      check_eq("bp_inst1",    InstOut,            32'hB000_0001);
      check_eq("bp_pcp41",    InstPCPlus4,        32'h8);
      ImemAck = 1'b0; ImemRdata = 32'hBAD0_0000;
      tick();
      check_eq("bp_req_low", {31'b0, ImemReq},   32'h0);
      check_eq("bp_hold",    InstOut,            32'hB000_0001);
      check_eq("bp_valid",   {31'b0, InstValid}, 32'h1);
      InstReady = 1'b1;
      tick();
      check_eq("bp_resume_req",  {31'b0, ImemReq}, 32'h1);
      check_eq("bp_resume_addr", ImemAddr,         32'h8);

      // Redirect while a fetch awaits its ack: address held, late data squashed
      ImemAck = 1'b1; ImemRdata = 32'hC000_0000;
      tick();
      check_eq("sq_fill", InstOut, 32'hC000_0000);
      ImemAck = 1'b0; InstReady = 1'b0;
      set_branch(1'b1, 32'h0000_0100, 32'h0000_0040);
      tick();
      check_eq("sq_addr_hold", ImemAddr,           32'hC);
      check_eq("sq_flush",     {31'b0, InstValid}, 32'h0);
      check_eq("sq_req",       {31'b0, ImemReq},   32'h1);
      set_branch(1'b0, 32'h0, 32'h0);
      tick();
      check_eq("sq_addr_hold2", ImemAddr, 32'hC);
      ImemAck = 1'b1; ImemRdata = 32'hDEAD_BEEF;
      tick();
      check_eq("sq_discard", {31'b0, InstValid}, 32'h0);
      check_eq("sq_inst",    InstOut,            32'hC000_0000);
      check_eq("sq_target",  ImemAddr,           32'h140);
      InstReady = 1'b1; ImemRdata = 32'hC000_0001;
      tick();
      check_eq("sq_new_inst", InstOut,     32'hC000_0001);
      check_eq("sq_new_pcp4", InstPCPlus4, 32'h144);
      check_eq("sq_new_addr", ImemAddr,    32'h144);

      // Redirect coinciding with ack, negative offset: 0x200 + (-16) = 0x1F0
      ImemRdata = 32'hBAD0_0001;
      set_branch(1'b1, 32'h0000_0200, 32'hFFFF_FFF0);
      tick();
      check_eq("ba_valid", {31'b0, InstValid}, 32'h0);
      check_eq("ba_inst",  InstOut,            32'hC000_0001);
      check_eq("ba_addr",  ImemAddr,           32'h1F0);
      set_branch(1'b0, 32'h0, 32'h0);
      ImemAck = 1'b0;
      tick();
      check_eq("ba_novalid", {31'b0, InstValid}, 32'h0);

      // Two redirects while squashed: last wins, 0xFFFF_FFFC + 8 wraps to 0x4
      set_branch(1'b1, 32'h0000_0300, 32'h0000_0010);
      tick();
      check_eq("rr_hold1", ImemAddr, 32'h1F0);
      set_branch(1'b1, 32'hFFFF_FFFC, 32'h0000_0008);
      tick();
      check_eq("rr_hold2", ImemAddr, 32'h1F0);
      set_branch(1'b0, 32'h0, 32'h0);
      ImemAck = 1'b1; ImemRdata = 32'hBAD0_0002;
      tick();
      check_eq("rr_wrap_target", ImemAddr,           32'h4);
      check_eq("rr_novalid",     {31'b0, InstValid}, 32'h0);

      // Sequential PC wraps from 0xFFFF_FFFC to 0
      set_branch(1'b1, 32'hFFFF_FFF8, 32'h0000_0000);
      tick();
      check_eq("pw_addr0", ImemAddr, 32'hFFFF_FFF8);
      set_branch(1'b0, 32'h0, 32'h0);
      ImemRdata = 32'hE000_0000;
      tick();
      check_eq("pw_addr1", ImemAddr,    32'hFFFF_FFFC);
      check_eq("pw_pcp41", InstPCPlus4, 32'hFFFF_FFFC);
      ImemRdata = 32'hE000_0001;
      tick();
      check_eq("pw_addr2", ImemAddr,    32'h0);
      check_eq("pw_pcp42", InstPCPlus4, 32'h0);
      check_eq("pw_inst2", InstOut,     32'hE000_0001);

      // Async reset in the middle of a squashed fetch
      ImemAck = 1'b0;
      set_branch(1'b1, 32'h0000_0100, 32'h0000_0040);
      tick();
      set_branch(1'b0, 32'h0, 32'h0);
      #2;
      Reset = 1'b1;
      #1;
      check_eq("ar_req",   {31'b0, ImemReq},   32'h0);
      check_eq("ar_addr",  ImemAddr,           32'h0);
      check_eq("ar_valid", {31'b0, InstValid}, 32'h0);
      check_eq("ar_inst",  InstOut,            32'h0);
      check_eq("ar_pcp4",  InstPCPlus4,        32'h0);
`ifdef PC_ALIGN_CHECK_EN
      check_eq("ar_misalign", {31'b0, MisalignErr}, 32'h0);
`endif
      tick();
      Reset = 1'b0;
      tick();
      check_eq("ar_restart_addr", ImemAddr,         32'h0);
      check_eq("ar_restart_req",  {31'b0, ImemReq}, 32'h1);
      ImemAck = 1'b1; ImemRdata = 32'hF000_0000;
      tick();
      check_eq("ar_no_squash", InstOut,            32'hF000_0000);
      check_eq("ar_valid1",    {31'b0, InstValid}, 32'h1);

      // Misaligned redirect target 0x100 + 2
      set_branch(1'b1, 32'h0000_0100, 32'h0000_0002);
      tick();
      set_branch(1'b0, 32'h0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
      check_eq("al_addr",     ImemAddr,             32'h100);
      check_eq("al_misalign", {31'b0, MisalignErr}, 32'h1);
      ImemAck = 1'b0;
      tick();
      check_eq("al_sticky",   {31'b0, MisalignErr}, 32'h1);
`else
      check_eq("al_addr_raw", ImemAddr, 32'h102);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
